lsu_pipe: RTL

LSU_PIPE -- requirements
Module: lsu_pipe

---
 rtl/lsu_pipe.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_pipe.sv
// lsu_pipe: load/store unit fronting a word-organised data memory, a bank of
// byte-writable output registers and a synchronised switch input.
//
// Address map (addr_i[15:12]):
//   4'h0  data memory, byte address addr_i[DMEM_AW-1:0]
//   4'h7  output register addr_i[11:4], byte lane addr_i[1:0]
//   4'h8  switches (load only, width ignored)
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_i / ready_o      request handshake, accepted when req_i && ready_o
//   we_i, width_i        store select, access width (b/h/w/bu/hu)
//   addr_i, st_data_i    byte address, right-aligned store data
//   valid_o, err_o       one-cycle completion pulse and its error qualifier
//   ld_data_o            load result, zero unless valid_o
//   io_sw_i              asynchronous switch inputs
//   io_out_o             flattened output registers, entry i at [32*i +: 32]
//
// Optional feature: define LSU_MISALIGN_EN to let data-memory accesses that
// straddle a word boundary complete in two beats; otherwise such accesses
// complete with err_o and the second beat does not exist.
module lsu_pipe #(
  parameter int unsigned DMEM_AW = 11,
  parameter int unsigned NUM_OUT = 11,
  parameter int unsigned SW_W    = 18
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   ready_o,
  input  logic                   we_i,
  input  logic [2:0]             width_i,
  input  logic [15:0]            addr_i,
  input  logic [31:0]            st_data_i,
  output logic                   valid_o,
  output logic                   err_o,
  output logic [31:0]            ld_data_o,
  input  logic [SW_W-1:0]        io_sw_i,
  output logic [NUM_OUT*32-1:0]  io_out_o
);

  localparam int unsigned WAW   = DMEM_AW - 2;
  localparam int unsigned DEPTH = 1 << WAW;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1
`ifdef LSU_MISALIGN_EN
    , BEAT2
`endif
  } state_t;

  state_t state;

  logic [31:0] mem [DEPTH];
  logic [31:0] out_q [NUM_OUT];
  logic [SW_W-1:0] sw_s1, sw_s2;

  // Request captured at acceptance; drives decode while the FSM is busy.
  logic [15:0] addr_q;
  logic        we_q;
  logic [2:0]  width_q;
  logic [31:0] data_q;
`ifdef LSU_MISALIGN_EN
  logic        split_q;
  logic [31:0] lo_q;
`endif

  logic [15:0]    addr;
  logic           we;
  logic [2:0]     width;
  logic [31:0]    data;
  logic           accept;
  logic [3:0]     region;
  logic [1:0]     off;
  logic [4:0]     sh;
  logic [2:0]     nbytes;
  logic [3:0]     mask;
  logic           bad_width, misaligned;
  logic           is_dmem, is_out, is_sw, out_hit, err, split;
  logic [WAW-1:0] w0;
  logic [31:0]    wd_lo;
  logic [3:0]     be_lo;
  logic [31:0]    out_rd, rd_word, load_data;
  logic           mem_we;
  logic [WAW-1:0] mem_idx;
  logic [31:0]    mem_wd;
  logic [3:0]     mem_be;
`ifdef LSU_MISALIGN_EN
  logic           span;
  logic [WAW-1:0] w1;
  logic [31:0]    wd_hi;
  logic [3:0]     be_hi;
  logic [31:0]    split_load;
`endif

  // Width-dependent sign/zero extension of a right-aligned load value.
  function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [2:0] w);
    case (w)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'b0, raw[7:0]};
      3'b101:  return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Decode of the access in flight: live inputs in IDLE, captured request otherwise.
  always_comb begin
    accept = req_i && ready_o;
    if (state == IDLE) begin
      addr  = addr_i;
      we    = we_i;
      width = width_i;
      data  = st_data_i;
    end else begin
      addr  = addr_q;
      we    = we_q;
      width = width_q;
      data  = data_q;
    end

    region = addr[15:12];
    off    = addr[1:0];
    sh     = {off, 3'b000};
    case (width[1:0])
      2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
      default: begin nbytes = 3'd4; mask = 4'b1111; end
    endcase
    bad_width  = !(width inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = (nbytes == 3'd2 && off[0]) || (nbytes == 3'd4 && off != 2'b00);
    w0    = addr[DMEM_AW-1:2];
    wd_lo = data << sh;
    be_lo = mask << off;

    is_dmem = (region == 4'h0);
    is_out  = (region == 4'h7);
    is_sw   = (region == 4'h8);

    out_hit = 1'b0;
    out_rd  = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (addr[11:4] == 8'(i)) begin
        out_hit = 1'b1;
        out_rd  = out_q[i];
      end
    end

`ifdef LSU_MISALIGN_EN
    span       = (3'(off) + nbytes) > 3'd4;
    w1         = w0 + WAW'(1);
    wd_hi      = data >> (6'd32 - 6'(sh));
    be_hi      = 4'((8'(mask) << off) >> 4);
    split_load = fmt((lo_q >> sh) | (mem[w1] << (6'd32 - 6'(sh))), width);
`endif

    err = bad_width;
    if (is_dmem) begin
`ifdef LSU_MISALIGN_EN
      // A straddle past the last word has no upper word to land in.
      if (span && (w0 == '1)) err = 1'b1;
`else
      if (misaligned) err = 1'b1;
`endif
    end else if (is_out) begin
      if (!out_hit || misaligned) err = 1'b1;
    end else if (is_sw) begin
      if (we || misaligned) err = 1'b1;
    end else begin
      err = 1'b1;
    end

`ifdef LSU_MISALIGN_EN
    split = is_dmem && span && !err;
`else
    split = 1'b0;
`endif

    rd_word   = is_out ? out_rd : mem[w0];
    load_data = is_sw ? 32'(sw_s2) : fmt(rd_word >> sh, width);

    // Lower word is written on the acceptance edge, upper word one edge later.
    mem_we  = 1'b0;
    mem_idx = w0;
    mem_wd  = wd_lo;
    mem_be  = be_lo;
    if (state == IDLE) begin
      mem_we = accept && we && is_dmem && !err;
`ifdef LSU_MISALIGN_EN
    end else if (state == BEAT1 && split_q) begin
      mem_we  = we;
      mem_idx = w1;
      mem_wd  = wd_hi;
      mem_be  = be_hi;
`endif
    end
    if (rst_i) mem_we = 1'b0;
  end

  // Data memory: byte-enabled write port, contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  // Control FSM, output registers, switch synchroniser and completion outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ready_o   <= 1'b0;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      ld_data_o <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      width_q   <= '0;
      data_q    <= '0;
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
`ifdef LSU_MISALIGN_EN
      split_q   <= 1'b0;
      lo_q      <= '0;
`endif
    end else begin
      sw_s1     <= io_sw_i;
      sw_s2     <= sw_s1;
      valid_o   <= 1'b0;
      err_o     <= 1'b0;
      ld_data_o <= '0;
      case (state)
        IDLE: begin
          ready_o <= 1'b1;
          if (accept) begin
            state   <= BEAT1;
            ready_o <= 1'b0;
            addr_q  <= addr_i;
            we_q    <= we_i;
            width_q <= width_i;
            data_q  <= st_data_i;
`ifdef LSU_MISALIGN_EN
            split_q <= split;
            lo_q    <= mem[w0];
`endif
            if (!split) begin
              valid_o <= 1'b1;
              err_o   <= err;
              if (!err && !we_i) ld_data_o <= load_data;
            end
            if (we_i && is_out && !err) begin
              for (int i = 0; i < NUM_OUT; i++) begin
                if (addr_i[11:4] == 8'(i)) begin
                  for (int b = 0; b < 4; b++) begin
                    if (be_lo[b]) out_q[i][8*b +: 8] <= wd_lo[8*b +: 8];
                  end
                end
              end
            end
          end
        end
        BEAT1: begin
`ifdef LSU_MISALIGN_EN
          if (split_q) begin
            state   <= BEAT2;
            valid_o <= 1'b1;
            if (!we_q) ld_data_o <= split_load;
          end else
`endif
          begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end
        end
`ifdef LSU_MISALIGN_EN
        BEAT2: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
`endif
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Output registers are exposed directly.
  always_comb begin
    io_out_o = '0;
    for (int i = 0; i < NUM_OUT; i++) io_out_o[32*i +: 32] = out_q[i];
  end

endmodule
